// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard controller: stall/flush, forwarding, memory-wait FSM,
// watchdog and saturating stall/flush counters for the five-stage core.
module hazard_unit #(
  parameter int REGISTER_ADDRESS_WIDTH = 5,
  parameter int CNT_WIDTH              = 32,
  parameter int MEM_TIMEOUT            = 1024
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic [1:0]                        ResultSrcE_i,
  input  logic                              RegWriteM_i,
  input  logic                              RegWriteW_i,
  input  logic                              PCSrcE_i,
  input  logic                              MemReqM_i,
  input  logic                              MemReadyM_i,
  output logic                              StallF_o,
  output logic                              StallD_o,
  output logic                              StallE_o,
  output logic                              StallM_o,
  output logic                              StallW_o,
  output logic                              FlushD_o,
  output logic                              FlushE_o,
  output logic [1:0]                        ForwardAE_o,
  output logic [1:0]                        ForwardBE_o,
  output logic                              MemTimeout_o,
  output logic [CNT_WIDTH-1:0]              StallCount_o,
  output logic [CNT_WIDTH-1:0]              FlushCount_o
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t                state_q, state_d;
  logic [WAIT_W-1:0]     wait_cnt_q;
  logic                  timeout_q;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, flush_cnt_q;
  logic                  load_use;
  logic                  mem_block;

  assign load_use = (ResultSrcE_i == 2'b01) && (RdE_i != '0) &&
                    ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  // In MEM_WAIT the wait persists until ready, even if the request drops.
  always_comb begin
    state_d   = state_q;
    StallF_o  = 1'b0;
    StallD_o  = 1'b0;
    StallE_o  = 1'b0;
    StallM_o  = 1'b0;
    StallW_o  = 1'b0;
    FlushD_o  = 1'b0;
    FlushE_o  = 1'b0;
    mem_block = (state_q == MEM_WAIT) ? !MemReadyM_i : (MemReqM_i && !MemReadyM_i);
    if (mem_block) begin
      StallF_o = 1'b1;
      StallD_o = 1'b1;
      StallE_o = 1'b1;
      StallM_o = 1'b1;
      StallW_o = 1'b1;
      state_d  = MEM_WAIT;
    end else begin
      state_d = RUN;
      if (PCSrcE_i) begin
        FlushD_o = 1'b1;
        FlushE_o = 1'b1;
      end else if (load_use) begin
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        FlushE_o = 1'b1;
      end
    end
    if (rst_i) begin
      StallF_o = 1'b0;
      StallD_o = 1'b0;
      StallE_o = 1'b0;
      StallM_o = 1'b0;
      StallW_o = 1'b0;
      FlushD_o = 1'b1;
      FlushE_o = 1'b1;
      state_d  = RUN;
    end
  end

  always_comb begin
    ForwardAE_o = 2'b00;
    ForwardBE_o = 2'b00;
    if (RegWriteM_i && (RdM_i != '0) && (RdM_i == Rs1E_i))      ForwardAE_o = 2'b10;
    else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == Rs1E_i)) ForwardAE_o = 2'b01;
    if (RegWriteM_i && (RdM_i != '0) && (RdM_i == Rs2E_i))      ForwardBE_o = 2'b10;
    else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == Rs2E_i)) ForwardBE_o = 2'b01;
    if (rst_i) begin
      ForwardAE_o = 2'b00;
      ForwardBE_o = 2'b00;
    end
  end

  // Wait counter is held at zero in RUN, so it is clear on every entry to MEM_WAIT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RUN)
        wait_cnt_q <= '0;
      else if (wait_cnt_q != WAIT_W'(MEM_TIMEOUT))
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      if ((state_q == MEM_WAIT) && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)))
        timeout_q <= 1'b1;
      if (StallF_o && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      if (FlushE_o && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign MemTimeout_o = timeout_q;
  assign StallCount_o = stall_cnt_q;
  assign FlushCount_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit: vector table, corner sequences,
// randomized traffic against a behavioural reference model.
module tb_hazard_unit;

  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int TO   = 4;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct packed {
    logic [AW-1:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0]    src;
    logic          regwm, regww, pcsrc, memreq, memready;
  } in_t;

  // exp bits: {SF,SD,SE,SM,SW, FD,FE, FA[1:0], FB[1:0]}
  typedef struct packed {
    in_t         in;
    logic [10:0] exp;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [AW-1:0] Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i;
  logic [1:0] ResultSrcE_i;
  logic RegWriteM_i, RegWriteW_i, PCSrcE_i, MemReqM_i, MemReadyM_i;
  logic StallF_o, StallD_o, StallE_o, StallM_o, StallW_o, FlushD_o, FlushE_o;
  logic [1:0] ForwardAE_o, ForwardBE_o;
  logic MemTimeout_o;
  logic [CW-1:0] StallCount_o, FlushCount_o;

  hazard_unit #(.REGISTER_ADDRESS_WIDTH(AW), .CNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i),
    .RdE_i(RdE_i), .RdM_i(RdM_i), .RdW_i(RdW_i), .ResultSrcE_i(ResultSrcE_i),
    .RegWriteM_i(RegWriteM_i), .RegWriteW_i(RegWriteW_i), .PCSrcE_i(PCSrcE_i),
    .MemReqM_i(MemReqM_i), .MemReadyM_i(MemReadyM_i),
    .StallF_o(StallF_o), .StallD_o(StallD_o), .StallE_o(StallE_o),
    .StallM_o(StallM_o), .StallW_o(StallW_o), .FlushD_o(FlushD_o), .FlushE_o(FlushE_o),
    .ForwardAE_o(ForwardAE_o), .ForwardBE_o(ForwardBE_o), .MemTimeout_o(MemTimeout_o),
    .StallCount_o(StallCount_o), .FlushCount_o(FlushCount_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  bit m_wait;
  int m_wcycles;
  bit m_to;
  int m_sc, m_fc;

  logic [10:0] outs;
  assign outs = {StallF_o, StallD_o, StallE_o, StallM_o, StallW_o,
                 FlushD_o, FlushE_o, ForwardAE_o, ForwardBE_o};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic in_t mk(input int rs1d, input int rs2d, input int rs1e, input int rs2e,
                             input int rde, input int rdm, input int rdw, input int src,
                             input bit regwm, input bit regww, input bit pcsrc);
    in_t v;
    v.rs1d = AW'(rs1d); v.rs2d = AW'(rs2d); v.rs1e = AW'(rs1e); v.rs2e = AW'(rs2e);
    v.rde = AW'(rde); v.rdm = AW'(rdm); v.rdw = AW'(rdw); v.src = 2'(src);
    v.regwm = regwm; v.regww = regww; v.pcsrc = pcsrc;
    v.memreq = 1'b0; v.memready = 1'b0;
    return v;
  endfunction

  function automatic logic [1:0] fwd(input in_t v, input logic [AW-1:0] rs);
    if (v.regwm && v.rdm != 0 && v.rdm == rs) return 2'b10;
    if (v.regww && v.rdw != 0 && v.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [10:0] model_comb(input in_t v, input bit rst);
    bit waiting_now;
    bit loaduse;
    if (rst) return 11'b00000_11_00_00;
    waiting_now = m_wait ? !v.memready : (v.memreq && !v.memready);
    loaduse = (v.src == 2'b01) && (v.rde != 0) && (v.rde == v.rs1d || v.rde == v.rs2d);
    if (waiting_now) return {5'b11111, 2'b00, fwd(v, v.rs1e), fwd(v, v.rs2e)};
    if (v.pcsrc)     return {5'b00000, 2'b11, fwd(v, v.rs1e), fwd(v, v.rs2e)};
    if (loaduse)     return {5'b11000, 2'b01, fwd(v, v.rs1e), fwd(v, v.rs2e)};
    return {5'b00000, 2'b00, fwd(v, v.rs1e), fwd(v, v.rs2e)};
  endfunction

  task automatic model_reset();
    m_wait = 0; m_wcycles = 0; m_to = 0; m_sc = 0; m_fc = 0;
  endtask

  task automatic model_step(input in_t v, input bit rst);
    logic [10:0] o;
    bit nw;
    if (rst) begin
      model_reset();
    end else begin
      o = model_comb(v, 1'b0);
      if (o[10]) m_sc = (m_sc < MAXC) ? m_sc + 1 : MAXC;
      if (o[4])  m_fc = (m_fc < MAXC) ? m_fc + 1 : MAXC;
      if (m_wait) begin
        m_wcycles++;
        if (m_wcycles >= TO) m_to = 1;
      end
      nw = m_wait ? !v.memready : (v.memreq && !v.memready);
      if (nw && !m_wait) m_wcycles = 0;
      m_wait = nw;
    end
  endtask

  task automatic drive(input in_t v);
    Rs1D_i = v.rs1d; Rs2D_i = v.rs2d; Rs1E_i = v.rs1e; Rs2E_i = v.rs2e;
    RdE_i = v.rde; RdM_i = v.rdm; RdW_i = v.rdw; ResultSrcE_i = v.src;
    RegWriteM_i = v.regwm; RegWriteW_i = v.regww; PCSrcE_i = v.pcsrc;
    MemReqM_i = v.memreq; MemReadyM_i = v.memready;
  endtask

  // One clock cycle: drive after the edge, compare at the falling edge, advance the model at the rising edge.
  task automatic apply(input in_t v, input bit rst, input bit use_model,
                       input logic [10:0] exp_in, input string name);
    logic [10:0] exp;
    drive(v);
    rst_i = rst;
    if (rst) model_reset();
    exp = use_model ? model_comb(v, rst) : exp_in;
    @(negedge clk_i);
    chk({name, "_outs"}, 32'(outs), 32'(exp));
    chk({name, "_stallcnt"}, 32'(StallCount_o), 32'(m_sc));
    chk({name, "_flushcnt"}, 32'(FlushCount_o), 32'(m_fc));
    chk({name, "_timeout"}, 32'(MemTimeout_o), 32'(m_to));
    @(posedge clk_i);
    model_step(v, rst);
    #1;
  endtask

  task automatic reset_dut();
    apply(mk(0,0,0,0,0,0,0,0,0,0,0), 1'b1, 1'b0, 11'b00000_11_00_00, "reset");
    rst_i = 1'b0;
  endtask

  vec_t vecs[9];
  in_t  v;

  initial begin
    #200000;
    $display("FAIL bench_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{in: mk(5,0,0,0,5,0,0,1,0,0,0), exp: 11'b11000_01_00_00};
    vecs[1] = '{in: mk(3,5,0,0,5,0,0,1,0,0,0), exp: 11'b11000_01_00_00};
    vecs[2] = '{in: mk(0,0,0,0,0,0,0,1,0,0,0), exp: 11'b00000_00_00_00};
    vecs[3] = '{in: mk(5,0,0,0,5,0,0,0,0,0,0), exp: 11'b00000_00_00_00};
    vecs[4] = '{in: mk(5,0,0,0,5,0,0,1,0,0,1), exp: 11'b00000_11_00_00};
    vecs[5] = '{in: mk(0,0,7,7,0,7,7,0,1,1,0), exp: 11'b00000_00_10_10};
    vecs[6] = '{in: mk(0,0,7,7,0,7,7,0,0,1,0), exp: 11'b00000_00_01_01};
    vecs[7] = '{in: mk(0,0,7,7,0,0,0,0,1,1,0), exp: 11'b00000_00_00_00};
    vecs[8] = '{in: mk(0,0,7,9,0,7,9,0,1,1,0), exp: 11'b00000_00_10_01};

    model_reset();
    @(posedge clk_i); #1;
    reset_dut();

    for (int i = 0; i < 9; i++) apply(vecs[i].in, 1'b0, 1'b0, vecs[i].exp, $sformatf("vec%0d", i));

    // Memory wait: three not-ready cycles then ready, forwarding held steady.
    reset_dut();
    v = mk(0,0,7,0,0,7,0,0,1,0,0);
    v.memreq = 1'b1;
    for (int i = 0; i < 3; i++) apply(v, 1'b0, 1'b0, 11'b11111_00_10_00, $sformatf("memwait%0d", i));
    v.memready = 1'b1;
    apply(v, 1'b0, 1'b0, 11'b00000_00_10_00, "memwait_exit");
    chk("memwait_stallcount", 32'(StallCount_o), 32'd3);

    // Watchdog: sets after TO wait cycles and stays set past the exit.
    reset_dut();
    v = mk(0,0,0,0,0,0,0,0,0,0,0);
    v.memreq = 1'b1;
    for (int i = 0; i < TO + 1; i++) apply(v, 1'b0, 1'b1, 11'b0, $sformatf("wdog%0d", i));
    chk("wdog_set", 32'(MemTimeout_o), 32'd1);
    v.memready = 1'b1;
    apply(v, 1'b0, 1'b1, 11'b0, "wdog_exit");
    apply(mk(0,0,0,0,0,0,0,0,0,0,0), 1'b0, 1'b1, 11'b0, "wdog_after");
    chk("wdog_sticky", 32'(MemTimeout_o), 32'd1);

    // Reset asserted mid-wait takes effect before the next edge.
    v.memready = 1'b0;
    apply(v, 1'b0, 1'b1, 11'b0, "prereset_wait");
    #2 rst_i = 1'b1;
    model_reset();
    #1;
    chk("midrst_stallF", 32'(StallF_o), 32'd0);
    chk("midrst_flushE", 32'(FlushE_o), 32'd1);
    chk("midrst_stallcnt", 32'(StallCount_o), 32'd0);
    chk("midrst_timeout", 32'(MemTimeout_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    apply(mk(0,0,0,0,0,0,0,0,0,0,0), 1'b0, 1'b0, 11'b00000_00_00_00, "postrst_run");

    // Saturation of both counters.
    reset_dut();
    for (int i = 0; i < 20; i++) apply(vecs[0].in, 1'b0, 1'b0, vecs[0].exp, "sat");
    chk("sat_stallcount", 32'(StallCount_o), 32'(MAXC));
    chk("sat_flushcount", 32'(FlushCount_o), 32'(MAXC));

    // Randomized traffic against the reference model.
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      v = mk($urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3),
             $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3),
             1'($urandom_range(0,1)), 1'($urandom_range(0,1)), ($urandom_range(0,3) == 0));
      v.memreq   = ($urandom_range(0,2) == 0);
      v.memready = ($urandom_range(0,1) == 0);
      apply(v, ($urandom_range(0,49) == 0), 1'b1, 11'b0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
